// File: rtl/multi_src_event_counter_if.sv
// ----------------------------------------------------------------------------
// multi_src_event_counter_if
//
// Purpose
//   Bundles the control inputs and the registered result outputs of
//   multi_src_event_counter so a driver and the counter share one connection.
//   W and NSRC must match the parameters of the counter attached to it.
//
// Signals
//   clr     1     synchronous clear of the counter
//   ld      1     load ld_val into the counter
//   ld_val  W     load value
//   inc     NSRC  increment requests, each set bit adds 1 this cycle
//   dec     1     decrement request, subtracts 1 this cycle
//   x       W     registered count, cnt one cycle delayed
//   hit     1     registered (cnt >= THR), aligned with x
//   ovf     1     one-cycle overflow pulse, aligned with x
//   unf     1     one-cycle underflow pulse, aligned with x
//   err     1     sticky ovf/unf flag, only when ECNT_STICKY_EN is defined
//
// Modports
//   master  drives clr/ld/ld_val/inc/dec, observes the results
//   slave   the counter itself
//
// There is no valid/ready handshake on this bundle: every input is sampled
// on every rising clock edge and every output is valid on every cycle.
// ----------------------------------------------------------------------------
interface multi_src_event_counter_if #(
    parameter int W    = 5,
    parameter int NSRC = 3
);
    logic            clr;
    logic            ld;
    logic [W-1:0]    ld_val;
    logic [NSRC-1:0] inc;
    logic            dec;
    logic [W-1:0]    x;
    logic            hit;
    logic            ovf;
    logic            unf;
`ifdef ECNT_STICKY_EN
    logic            err;
`endif

    modport master (
        output clr, ld, ld_val, inc, dec,
`ifdef ECNT_STICKY_EN
        input  err,
`endif
        input  x, hit, ovf, unf
    );

    modport slave (
        input  clr, ld, ld_val, inc, dec,
`ifdef ECNT_STICKY_EN
        output err,
`endif
        output x, hit, ovf, unf
    );
endinterface

// File: rtl/multi_src_event_counter.sv
// ----------------------------------------------------------------------------
// multi_src_event_counter
//
// Purpose
//   Generic event / occupancy counter. Each cycle it adds the number of set
//   bits of inc and subtracts dec. Supports synchronous clear, load, wrap or
//   saturate on range exit, overflow / underflow pulses and a threshold flag.
//   The count is published through a one-cycle output pipeline register, so
//   an input sampled at edge E changes cnt at E and shows on x at E+1.
//
// Parameters
//   W     counter width in bits (2..32)
//   NSRC  number of increment request inputs (1..16)
//   SAT   0 = wrap modulo 2^W, 1 = saturate at 0 and 2^W-1
//   THR   threshold compared against the count (0..2^W-1)
//
// Ports
//   clk   in   single clock, all logic on posedge
//   rst   in   synchronous reset, active-high
//   bus   slave modport of multi_src_event_counter_if:
//           clr, ld, ld_val, inc, dec  in
//           x, hit, ovf, unf           out (all registered)
//           err                        out, sticky flag (ECNT_STICKY_EN only)
//
// Configuration
//   ECNT_STICKY_EN  when defined, adds the sticky err output: set together
//                   with an ovf/unf pulse, cleared by rst or clr (clr wins
//                   over a same-cycle set). When undefined the port and its
//                   register are absent.
//
// Priority of counter updates: rst > clr > ld > inc/dec.
// ----------------------------------------------------------------------------
module multi_src_event_counter #(
    parameter int W    = 5,
    parameter int NSRC = 3,
    parameter int SAT  = 0,
    parameter int THR  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    multi_src_event_counter_if.slave      bus
);

    // Popcount of inc needs to hold 0..NSRC.
    localparam int CW = $clog2(NSRC + 1);
    // Signed arithmetic width: wide enough that cnt + NSRC - 1 never wraps,
    // so the range checks see the true result.
    localparam int RW = W + $clog2(NSRC + 2) + 1;

    localparam logic signed [RW-1:0] MAX_V = {{(RW-W){1'b0}}, {W{1'b1}}};
    localparam logic [W-1:0]         THR_V = THR[W-1:0];
    localparam logic                 HIT_RST = (THR == 0);

    // ------------------------------------------------------------------
    // Counter stage
    // ------------------------------------------------------------------
    logic [W-1:0]          cnt;
    logic                  ovf_q;   // flag of the update that produced cnt
    logic                  unf_q;

    logic [CW-1:0]         pop;
    logic signed [RW-1:0]  r;
    logic [W-1:0]          cnt_next;
    logic                  ovf_next;
    logic                  unf_next;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NSRC; i++) begin
            pop = pop + CW'(bus.inc[i]);
        end
    end

    always_comb begin
        r = $signed({{(RW-W){1'b0}}, cnt})
          + $signed({{(RW-CW){1'b0}}, pop})
          - $signed({{(RW-1){1'b0}}, bus.dec});
    end

    always_comb begin
        cnt_next = cnt;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (bus.clr) begin
            cnt_next = '0;
        end else if (bus.ld) begin
            cnt_next = bus.ld_val;
        end else if (r > MAX_V) begin
            ovf_next = 1'b1;
            cnt_next = (SAT != 0) ? {W{1'b1}} : r[W-1:0];
        end else if (r[RW-1]) begin
            // Negative result: low W bits are already r mod 2^W.
            unf_next = 1'b1;
            cnt_next = (SAT != 0) ? '0 : r[W-1:0];
        end else begin
            cnt_next = r[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            ovf_q <= ovf_next;
            unf_q <= unf_next;
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline stage: publishes cnt and its flags one cycle later.
    // Cleared in the same edge as cnt so no stale value survives rst.
    // ------------------------------------------------------------------
    logic [W-1:0] x_q;
    logic         hit_q;
    logic         ovf_o;
    logic         unf_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            hit_q <= HIT_RST;
            ovf_o <= 1'b0;
            unf_o <= 1'b0;
        end else begin
            x_q   <= cnt;
            hit_q <= (cnt >= THR_V);
            ovf_o <= ovf_q;
            unf_o <= unf_q;
        end
    end

    assign bus.x   = x_q;
    assign bus.hit = hit_q;
    assign bus.ovf = ovf_o;
    assign bus.unf = unf_o;

`ifdef ECNT_STICKY_EN
    // Sticky error: rises in the same cycle the ovf/unf pulse appears on the
    // outputs, hence it is fed from the counter-stage flags.
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.clr) begin
            err_q <= 1'b0;
        end else if (ovf_q || unf_q) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif

endmodule
